// File: rtl/sn76489_pkg.sv
// Shared types and defaults for the SN76489 CPU write front end.
package sn76489_pkg;

  localparam int WAIT_CYCLES_DEF = 32;
  localparam int CNT_W           = 5;

  typedef enum logic [1:0] {
    CH_TONE1 = 2'd0,
    CH_TONE2 = 2'd1,
    CH_TONE3 = 2'd2,
    CH_NOISE = 2'd3
  } ch_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STROBE  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/sn76489_reg_decode.sv
// Combinational decode of a CPU byte: latch bytes load a new register
// address, data bytes reuse the latched one.
module sn76489_reg_decode
  import sn76489_pkg::*;
(
  input  logic [0:7] d_i,
  input  logic [0:2] reg_q,
  output logic [0:2] reg_nxt,
  output ch_t        ch,
  output logic       r2
);

  // Only the type bit and the register field matter for decoding.
  logic unused_data_bits;
  assign unused_data_bits = ^d_i[4:7];

  always_comb begin
    reg_nxt = reg_q;
    if (d_i[0]) begin
      reg_nxt = d_i[1:3];
    end
    ch = ch_t'(reg_nxt[0:1]);
    r2 = reg_nxt[2];
  end

endmodule

// File: rtl/sn76489_bus_if.sv
// SN76489 CPU write front end: edge-detects CPU writes, strobes one channel,
// drives READY. Define SN76489_READY_EN to compile in the READY wait state.
module sn76489_bus_if
  import sn76489_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic       clock_i,
  input  logic       res_i,
  input  logic       clk_en_i,
  input  logic       ce_n_i,
  input  logic       we_n_i,
  input  logic [0:7] d_i,
  output logic       ready_o,
  output logic       tone1_we_o,
  output logic       tone2_we_o,
  output logic       tone3_we_o,
  output logic       noise_we_o,
  output logic       r2_o,
  output logic [0:7] d_o
);

  state_t     state_q, state_d;
  logic       access, access_q, new_write, accept;
  logic [0:2] reg_q, reg_nxt;
  ch_t        ch_q, ch_nxt;
  logic       r2_nxt;
  logic       strobe;

  // Valid/ready: a write is offered on the rising edge of access and taken
  // only while ready_o is high in IDLE; offers in any other state are dropped.
  assign access    = ~ce_n_i & ~we_n_i;
  assign new_write = access & ~access_q;
  assign accept    = (state_q == ST_IDLE) & new_write;

  sn76489_reg_decode u_decode (
    .d_i     (d_i),
    .reg_q   (reg_q),
    .reg_nxt (reg_nxt),
    .ch      (ch_nxt),
    .r2      (r2_nxt)
  );

  always_ff @(posedge clock_i) begin
    if (res_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // access_q resets high so an access held through reset is not a new write.
  always_ff @(posedge clock_i) begin
    if (res_i) begin
      access_q <= 1'b1;
      reg_q    <= 3'b000;
      ch_q     <= CH_TONE1;
      r2_o     <= 1'b0;
      d_o      <= 8'h00;
    end else begin
      access_q <= access;
      if (accept) begin
        reg_q <= reg_nxt;
        ch_q  <= ch_nxt;
        r2_o  <= r2_nxt;
        d_o   <= d_i;
      end
    end
  end

`ifdef SN76489_READY_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             cnt_last;

  always_ff @(posedge clock_i) begin
    if (res_i) begin
      cnt_q <= '0;
    end else if (state_q != ST_WAIT) begin
      cnt_q <= '0;
    end else if (clk_en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_last = (cnt_q == CNT_LAST);
`else
  logic unused_wait_cycles;
  assign unused_wait_cycles = (WAIT_CYCLES != 0);
`endif

  always_comb begin
    state_d = state_q;
    ready_o = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        ready_o = 1'b0;
        // The strobe is consumed by the first enabled channel clock.
        if (clk_en_i) begin
`ifdef SN76489_READY_EN
          state_d = ST_WAIT;
`else
          state_d = ST_RELEASE;
`endif
        end
      end
      ST_WAIT: begin
`ifdef SN76489_READY_EN
        ready_o = 1'b0;
        if (clk_en_i && cnt_last) begin
          state_d = ST_RELEASE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_RELEASE: begin
        if (!access) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign strobe     = (state_q == ST_STROBE);
  assign tone1_we_o = strobe && (ch_q == CH_TONE1);
  assign tone2_we_o = strobe && (ch_q == CH_TONE2);
  assign tone3_we_o = strobe && (ch_q == CH_TONE3);
  assign noise_we_o = strobe && (ch_q == CH_NOISE);

endmodule

// File: tb/tb_sn76489_bus_if.sv
// Bench for sn76489_bus_if: write-level model with scoreboard, per-cycle
// compare, and directed byte sequences with literal expectations.
`timescale 1ns/1ps
module tb_sn76489_bus_if;

  localparam int WAIT_CYCLES = 32;
`ifdef SN76489_READY_EN
  localparam bit READY_EN = 1'b1;
`else
  localparam bit READY_EN = 1'b0;
`endif

  // ---------------- clock / reset / pins ----------------
  logic       clock_i = 1'b0;
  logic       res_i   = 1'b1;
  logic       clk_en_i = 1'b1;
  logic       ce_n_i  = 1'b1;
  logic       we_n_i  = 1'b1;
  logic [7:0] cpu_byte = 8'h00;
  logic [7:0] d_out;
  logic       ready_o, tone1_we_o, tone2_we_o, tone3_we_o, noise_we_o, r2_o;

  always #5 clock_i = ~clock_i;

  sn76489_bus_if #(.WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clock_i    (clock_i),
    .res_i      (res_i),
    .clk_en_i   (clk_en_i),
    .ce_n_i     (ce_n_i),
    .we_n_i     (we_n_i),
    .d_i        (cpu_byte),
    .ready_o    (ready_o),
    .tone1_we_o (tone1_we_o),
    .tone2_we_o (tone2_we_o),
    .tone3_we_o (tone3_we_o),
    .noise_we_o (noise_we_o),
    .r2_o       (r2_o),
    .d_o        (d_out)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- clock enable pattern ----------------
  int en_mode = 0;  // 0: always on, 1: one in four, 2: off
  int phase   = 0;
  initial begin
    forever begin
      @(posedge clock_i);
      #2;
      phase = (phase + 1) % 4;
      case (en_mode)
        0:       clk_en_i = 1'b1;
        1:       clk_en_i = (phase == 0);
        default: clk_en_i = 1'b0;
      endcase
    end
  end

  // ---------------- model ----------------
  // Expected strobe entries: {one-hot we[3:0], r2, byte[7:0]}
  logic [12:0] exp_q[$];
  int          wait_left  = 0;
  bit          in_release = 1'b0;
  bit          prev_a     = 1'b1;
  logic [2:0]  m_reg      = 3'b000;
  logic        m_r2       = 1'b0;
  logic [7:0]  m_d        = 8'h00;

  initial begin
    logic a, rise, r2;
    int   ch;
    forever begin
      @(posedge clock_i);
      a = !ce_n_i && !we_n_i;
      if (res_i) begin
        exp_q.delete();
        wait_left  = 0;
        in_release = 1'b0;
        prev_a     = 1'b1;
        m_reg      = 3'b000;
        m_r2       = 1'b0;
        m_d        = 8'h00;
      end else begin
        rise   = a && !prev_a;
        prev_a = a;
        if (exp_q.size() != 0) begin
          if (clk_en_i) begin
            void'(exp_q.pop_front());
            if (READY_EN) wait_left = WAIT_CYCLES;
            else in_release = 1'b1;
          end
        end else if (wait_left > 0) begin
          if (clk_en_i) begin
            wait_left--;
            if (wait_left == 0) in_release = 1'b1;
          end
        end else if (in_release) begin
          if (!a) in_release = 1'b0;
        end else if (rise) begin
          if (cpu_byte >= 8'h80) m_reg = 3'((cpu_byte >> 4) & 8'h07);
          ch = int'(m_reg) / 2;
          r2 = 1'(m_reg % 2);
          exp_q.push_back({4'(1 << ch), r2, cpu_byte});
          m_d  = cpu_byte;
          m_r2 = r2;
        end
      end
    end
  end

  // ---------------- compare + monitor ----------------
  int         strobe_cycles = 0;
  int         en_strobes    = 0;
  int         low_pulses    = 0;
  logic [3:0] last_we = 4'b0;
  logic       last_r2 = 1'b0;
  logic [7:0] last_d  = 8'h00;

  initial begin
    logic [3:0] we_vec, exp_we;
    logic       exp_ready;
    forever begin
      @(negedge clock_i);
      if (cmp_on) begin
        we_vec    = {noise_we_o, tone3_we_o, tone2_we_o, tone1_we_o};
        exp_we    = (exp_q.size() != 0) ? exp_q[0][12:9] : 4'b0000;
        exp_ready = (exp_q.size() == 0) && (wait_left == 0);
        check("ready", ready_o, exp_ready);
        check("we", we_vec, exp_we);
        check("we_onehot", ($countones(we_vec) <= 1), 1);
        check("d_o", d_out, m_d);
        check("r2", r2_o, m_r2);
        if (we_vec != 4'b0000) begin
          strobe_cycles++;
          if (clk_en_i) begin
            en_strobes++;
            last_we = we_vec;
            last_r2 = r2_o;
            last_d  = d_out;
          end
        end else if (!ready_o && clk_en_i) begin
          low_pulses++;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic set_access(input bit on, input logic [7:0] b);
    @(posedge clock_i);
    #2;
    ce_n_i = !on;
    we_n_i = !on;
    if (on) cpu_byte = b;
  endtask

  task automatic pulse(input logic [7:0] b);
    set_access(1'b1, b);
    set_access(1'b0, b);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clock_i);
      n++;
    end while ((!ready_o || exp_q.size() != 0 || wait_left != 0) && n < limit);
    check("ready_after_wait", ready_o, 1);
    repeat (2) @(negedge clock_i);
  endtask

  task automatic write_and_check(input string name, input logic [7:0] b,
                                 input logic [3:0] we, input logic r2);
    int s;
    s = en_strobes;
    pulse(b);
    wait_idle(500);
    check({name, "_count"}, en_strobes - s, 1);
    check({name, "_we"}, last_we, we);
    check({name, "_r2"}, last_r2, r2);
    check({name, "_d"}, last_d, b);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int s, lp, sc;
    // Access held active through reset must not become a write.
    res_i = 1'b1; ce_n_i = 1'b0; we_n_i = 1'b0; cpu_byte = 8'h8A;
    @(posedge clock_i); #2;
    cmp_on = 1'b1;
    @(negedge clock_i);
    check("rst_ready", ready_o, 1);
    check("rst_we", {noise_we_o, tone3_we_o, tone2_we_o, tone1_we_o}, 0);
    check("rst_d", d_out, 8'h00);
    check("rst_r2", r2_o, 0);
    @(posedge clock_i); #2 res_i = 1'b0;
    repeat (3) @(negedge clock_i);
    check("held_no_strobe", strobe_cycles, 0);
    set_access(1'b0, 8'h00);
    repeat (2) @(negedge clock_i);

    // Latch tone1 frequency; READY wait length.
    lp = low_pulses;
    write_and_check("w8a", 8'h8A, 4'b0001, 1'b0);
    check("w8a_wait_pulses", low_pulses - lp, READY_EN ? WAIT_CYCLES : 0);

    write_and_check("we5", 8'hE5, 4'b1000, 1'b0);
    write_and_check("w12", 8'h12, 4'b1000, 1'b0);
    write_and_check("wdf", 8'hDF, 4'b0100, 1'b1);
    write_and_check("w00", 8'h00, 4'b0100, 1'b1);

    // Sparse clock enable: strobe held until consumed exactly once.
    @(negedge clock_i); en_mode = 1;
    sc = strobe_cycles;
    write_and_check("wb0", 8'hB0, 4'b0010, 1'b1);
    check("wb0_hold_le4", (strobe_cycles - sc) <= 4, 1);
    @(negedge clock_i); en_mode = 0;
    repeat (2) @(negedge clock_i);

    // Reset while the strobe is stalled aborts the write.
    @(negedge clock_i); en_mode = 2;
    s = en_strobes;
    pulse(8'hC7);
    @(posedge clock_i); #2 res_i = 1'b1;
    @(negedge clock_i); en_mode = 0;
    @(posedge clock_i); #2 res_i = 1'b0;
    @(negedge clock_i);
    check("abort_ready", ready_o, 1);
    check("abort_no_strobe", en_strobes - s, 0);
    check("abort_d", d_out, 8'h00);
    write_and_check("w03", 8'h03, 4'b0001, 1'b0);

    // Reset during the READY wait with access low.
    s = en_strobes;
    pulse(8'h95);
    repeat (6) @(negedge clock_i);
    @(posedge clock_i); #2 res_i = 1'b1;
    @(posedge clock_i); #2 res_i = 1'b0;
    @(negedge clock_i);
    check("wait_rst_ready", ready_o, 1);
    check("wait_rst_strobes", en_strobes - s, 1);
    write_and_check("w10", 8'h10, 4'b0001, 1'b0);

    // A second access pulse right after the strobe is ignored.
    s = en_strobes;
    pulse(8'hC4);
    set_access(1'b1, 8'h8F);
    set_access(1'b0, 8'h8F);
    wait_idle(500);
    check("second_count", en_strobes - s, 1);
    check("second_we", last_we, 4'b0100);
    check("second_d", d_out, 8'hC4);
    check("second_r2", r2_o, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
